// File: rtl/token_pkg.sv
// token_pkg: shared FSM states, defaults and sizing helpers for the token doubling arbiter
package token_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int MAX_RUN_DEF = 200;
  localparam int CNT_W = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector starting just after the last winner
module rr_pick
  import token_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = idx_w(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [LW-1:0] index,
  output logic          valid
);
  // scan last+1, last+2, ... modulo N and keep the first eligible requester
  always_comb begin
    onehot = '0;
    index = last;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!valid && eligible[(int'(last) + k) % N]) begin
        valid = 1'b1;
        onehot[(int'(last) + k) % N] = 1'b1;
        index = LW'((int'(last) + k) % N);
      end
    end
  end
endmodule

// File: rtl/token_double_arbiter.sv
// token_double_arbiter: round-robin arbiter sharing one serial token doubler between requesters
module token_double_arbiter
  import token_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_RUN = MAX_RUN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] a,
  output logic [N_REQ-1:0] grant,
  output logic             b,
  output logic             busy,
  output logic [N_REQ-1:0] overflow
);
  localparam int LW = idx_w(N_REQ);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RUN);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [LW-1:0] last, last_n, pick_index;
  logic [N_REQ-1:0] grant_n, overflow_n, pick_onehot, eligible;
  logic b_n, pick_valid, live, tok, has_debt;
  assign eligible = req & ~overflow;
  assign live = req[last];
  assign tok = live & a[last];
  assign has_debt = cnt != '0;
  assign busy = state != IDLE;
  rr_pick #(.N(N_REQ), .LW(LW)) u_pick (
    .eligible(eligible),
    .last(last),
    .onehot(pick_onehot),
    .index(pick_index),
    .valid(pick_valid)
  );
  // next state: every '1' token adds one debt cycle, every idle cycle pays one back
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    b_n = 1'b0;
    grant_n = grant;
    last_n = last;
    overflow_n = overflow;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_n = pick_onehot;
          last_n = pick_index;
          state_n = RUN;
        end
      end
      RUN: begin
        if (tok && cnt == MAX_CNT) begin
          overflow_n[last] = 1'b1;
          cnt_n = '0;
          grant_n = '0;
          state_n = IDLE;
        end else if (tok) begin
          cnt_n = cnt + 1'b1;
          b_n = 1'b1;
        end else begin
          cnt_n = has_debt ? cnt - 1'b1 : cnt;
          b_n = has_debt;
          if (!live) begin
            grant_n = '0;
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        cnt_n = has_debt ? cnt - 1'b1 : cnt;
        b_n = has_debt;
        state_n = has_debt ? DRAIN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register; reset abandons any outstanding debt
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      b <= 1'b0;
      grant <= '0;
      last <= LW'(N_REQ - 1);
      overflow <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      b <= b_n;
      grant <= grant_n;
      last <= last_n;
      overflow <= overflow_n;
    end
  end
endmodule

// File: tb/tb_token_double_arbiter.sv
// tb_token_double_arbiter: scoreboard bench for the token doubling arbiter
module tb_token_double_arbiter;
  localparam int N = 4;
  localparam int MR = 200;
  typedef struct packed {
    logic b;
    logic busy;
    logic [N-1:0] grant;
    logic [N-1:0] ovf;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] a = '0;
  logic [N-1:0] grant, overflow;
  logic b, busy;
  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];
  int m_st = 0;
  int m_cnt = 0;
  int m_last = N - 1;
  logic m_b = 1'b0;
  logic [N-1:0] m_grant = '0;
  logic [N-1:0] m_ovf = '0;
  logic b_trace[$];
  logic quiet_trace[$];
  int b_ones = 0;
  int order[$];
  logic [N-1:0] prev_grant = '0;

  token_double_arbiter #(.N_REQ(N), .MAX_RUN(MR)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a),
    .grant(grant), .b(b), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference behaviour of one clock edge, from the current inputs
  task automatic model_edge();
    logic [N-1:0] el;
    logic found;
    int g;
    if (!rst) begin
      m_st = 0; m_cnt = 0; m_b = 1'b0; m_grant = '0; m_ovf = '0; m_last = N - 1;
    end else begin
      m_b = 1'b0;
      if (m_st == 0) begin
        el = req & ~m_ovf;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          g = (m_last + k) % N;
          if (!found && el[g]) begin
            found = 1'b1;
            m_grant = '0;
            m_grant[g] = 1'b1;
            m_last = g;
            m_st = 1;
          end
        end
      end else if (m_st == 1) begin
        g = m_last;
        if (!req[g]) begin
          m_grant = '0;
          m_st = 2;
          if (m_cnt > 0) begin m_cnt--; m_b = 1'b1; end
        end else if (a[g]) begin
          if (m_cnt == MR) begin
            m_ovf[g] = 1'b1; m_cnt = 0; m_grant = '0; m_st = 0;
          end else begin
            m_cnt++; m_b = 1'b1;
          end
        end else if (m_cnt > 0) begin
          m_cnt--; m_b = 1'b1;
        end
      end else begin
        if (m_cnt > 0) begin m_cnt--; m_b = 1'b1; end
        else m_st = 0;
      end
    end
  endtask

  // drive one cycle, push the expected outcome, then compare it on the falling edge
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] av, input logic rs = 1'b1);
    obs_t e;
    req = r;
    a = av;
    rst = rs;
    @(posedge clk);
    model_edge();
    exp_q.push_back('{b: m_b, busy: (m_st != 0), grant: m_grant, ovf: m_ovf});
    @(negedge clk);
    e = exp_q.pop_front();
    check("b", 64'(b), 64'(e.b));
    check("busy", 64'(busy), 64'(e.busy));
    check("grant", 64'(grant), 64'(e.grant));
    check("overflow", 64'(overflow), 64'(e.ovf));
    b_trace.push_back(b);
    if (b) b_ones++;
    if (prev_grant == '0 && grant != '0)
      for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
    prev_grant = grant;
  endtask

  task automatic noise_run(input logic noisy);
    logic [15:0] pat;
    logic [N-1:0] av;
    pat = 16'b1011_0011_1000_1101;
    step('0, '0, 1'b0);
    b_trace.delete();
    step(4'b0100, '0);
    for (int i = 0; i < 16; i++) begin
      av = '0;
      av[2] = pat[i];
      if (noisy) begin
        av[0] = 1'($urandom_range(0, 1));
        av[3] = 1'($urandom_range(0, 1));
      end
      step(4'b0100, av);
    end
    for (int i = 0; i < 24; i++)
      step('0, noisy ? N'($urandom_range(0, 15)) & 4'b1001 : '0);
  endtask

  initial begin
    logic [5:0] bv;
    logic sent;
    logic [N-1:0] r, av;
    logic ovf_now;
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    check("reset_grant", 64'(grant), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    b_trace.delete();
    step(4'b0001, '0);
    step(4'b0001, 4'b0001);
    step(4'b0001, 4'b0001);
    step(4'b0001, '0);
    step('0, '0);
    step('0, '0);
    step('0, '0);
    for (int i = 0; i < 6; i++) bv[i] = b_trace[i];
    check("burst_b_c1_c6", 64'(bv), 64'b011110);
    check("burst_idle_busy", 64'(busy), 64'd0);

    step('0, '0, 1'b0);
    order.delete();
    sent = 1'b0;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      r = '1;
      av = '0;
      if (m_st == 1) begin
        if (!sent) begin av[m_last] = 1'b1; sent = 1'b1; end
        else begin r[m_last] = 1'b0; sent = 1'b0; end
      end
      step(r, av);
    end
    check("rr_count", 64'(order.size()), 64'd5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check("rr_order", 64'(order[i]), 64'(i % N));
    for (int i = 0; i < 6; i++) step('0, '0);

    step('0, '0, 1'b0);
    step(4'b0010, '0);
    check("ovf_grant1", 64'(grant), 64'b0010);
    for (int i = 0; i < MR + 1; i++) step(4'b0010, 4'b0010);
    check("ovf_flag", 64'(overflow), 64'b0010);
    check("ovf_b", 64'(b), 64'd0);
    check("ovf_grant_off", 64'(grant), 64'd0);
    step(4'b0110, '0);
    check("ovf_serve2", 64'(grant), 64'b0100);
    step(4'b0110, 4'b0100);
    step(4'b0010, '0);
    for (int i = 0; i < 8; i++) begin
      step(4'b0010, 4'b0010);
      check("ovf_excluded", 64'(grant[1]), 64'd0);
    end

    step('0, '0, 1'b0);
    step(4'b0010, '0);
    b_ones = 0;
    for (int i = 0; i < MR; i++) step(4'b0010, 4'b0010);
    for (int i = 0; i < MR + 6; i++) step('0, '0);
    check("bound_b_cycles", 64'(b_ones), 64'd400);
    check("bound_no_ovf", 64'(overflow), 64'd0);

    step('0, '0, 1'b0);
    step(4'b0001, '0);
    for (int i = 0; i < 51; i++) step(4'b0001, 4'b0001);
    step('0, '0);
    check("drain_busy", 64'(busy), 64'd1);
    step(4'b1111, '0, 1'b0);
    check("rst_drain_b", 64'(b), 64'd0);
    check("rst_drain_busy", 64'(busy), 64'd0);
    check("rst_drain_ovf", 64'(overflow), 64'd0);
    step(4'b1111, '0);
    check("rst_first_grant", 64'(grant), 64'b0001);
    ovf_now = 1'b0;
    step('0, '0);
    step('0, '0);

    noise_run(1'b0);
    quiet_trace = b_trace;
    noise_run(1'b1);
    check("noise_len", 64'(b_trace.size()), 64'(quiet_trace.size()));
    for (int i = 0; i < b_trace.size() && i < quiet_trace.size(); i++)
      check("noise_b", 64'(b_trace[i]), 64'(quiet_trace[i]));
    check("noise_unused", 64'(ovf_now), 64'(overflow[0]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
